// File: rtl/instr_fetch_pp.sv
// Instruction-fetch stage: owns the word-indexed PC, reads the combinational ROM,
// and loads the IF/ID register. Branch and jump redirects and hazard stalls are applied here.
module instr_fetch_pp #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC_Out,
  input  logic [31:0] Instr_In,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [25:0] Jump_Index,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC_Plus1,
  output logic        IFID_Valid,
  output logic        Fetch_Done,
  output logic [15:0] Fetch_Count
);

  // The handshake toward decode is valid-only. IFID_Valid=1 marks a real instruction.
  // Decode has no ready signal; back-pressure arrives only as Stall, which holds PC and IF/ID.
  typedef enum logic {RUN, DONE} state_t;

  localparam logic [32:0] DEPTH = 33'(MEM_DEPTH);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [32:0] pc_inc;
  logic        pc_in_range;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        redirect_in_range;

  // The PC is incremented at 33 bits so that a wrap at 2^32 still counts as past the end of the ROM.
  assign pc_inc            = {1'b0, pc} + 33'd1;
  assign pc_in_range       = ({1'b0, pc} < DEPTH);
  assign jump_target       = {ifid_pc_plus1[31:26], Jump_Index};
  assign redirect          = Branch_Taken | Jump;
  assign redirect_target   = Branch_Taken ? Branch_Target : jump_target;
  assign redirect_in_range = ({1'b0, redirect_target} < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
      fetch_count   <= 16'd0;
    end else if (redirect) begin
      // A branch outranks a jump. Both squash the slot being fetched, and a stall does not block them.
      pc         <= redirect_target;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      state      <= redirect_in_range ? RUN : DONE;
    end else if (state == DONE || !pc_in_range) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      state      <= DONE;
    end else if (!Stall) begin
      ifid_instr    <= Instr_In;
      ifid_pc_plus1 <= pc_inc[31:0];
      ifid_valid    <= 1'b1;
      if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      // The last word is still captured. The PC then parks on it instead of stepping past the end.
      if (pc_inc >= DEPTH) state <= DONE;
      else                 pc    <= pc_inc[31:0];
    end
  end

  assign PC_Out        = pc;
  assign IFID_Instr    = ifid_instr;
  assign IFID_PC_Plus1 = ifid_pc_plus1;
  assign IFID_Valid    = ifid_valid;
  assign Fetch_Done    = (state == DONE);
  assign Fetch_Count   = fetch_count;

endmodule
